// File: rtl/stim_sweep_pkg.sv
// Shared types and helpers for the stimulus sweep generator.
package stim_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } sweep_state_t;

    // Hold-counter width: $clog2(HOLD), never narrower than one bit.
    function automatic int hold_w(input int hold);
        return (hold > 2) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/stim_hold_timer.sv
// Loadable down-counter that flags the last cycle of a HOLD-1 cycle freeze.
// With HOLD==1 there is no freeze, so expire simply follows load.
module stim_hold_timer
    import stim_sweep_pkg::*;
#(
    parameter int HOLD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int CW       = hold_w(HOLD);
    localparam int LOAD_INT = (HOLD > 1) ? HOLD - 2 : 0;

    logic [CW-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LOAD_INT);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = (HOLD == 1) ? load : (cnt == '0);

endmodule

// File: rtl/stim_sweep_gen.sv
// Ranged/exhaustive stimulus sweep source, one vector per handshake.
// Define STIM_SWEEP_GRAY_EN to present vectors in Gray order instead of binary.
module stim_sweep_gen
    import stim_sweep_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int HOLD  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic             vec_ready,
    output logic [WIDTH-1:0] vec_out,
    output logic             vec_valid,
    output logic [WIDTH:0]   vec_cnt,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int CW = WIDTH + 1;

    sweep_state_t     state, state_nxt;
    logic [WIDTH-1:0] cur, cur_nxt, last, last_nxt;
    logic [WIDTH:0]   cnt_nxt;
    logic             valid_nxt, busy_nxt, done_nxt, aborted_nxt;
    logic             accept, adv, timer_load, timer_expire;

    function automatic logic [WIDTH-1:0] to_vec(input logic [WIDTH-1:0] idx);
`ifdef STIM_SWEEP_GRAY_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

    stim_hold_timer #(.HOLD(HOLD)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .expire (timer_expire)
    );

    assign accept = vec_valid && vec_ready;

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cur_nxt     = cur;
        last_nxt    = last;
        cnt_nxt     = vec_cnt;
        valid_nxt   = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        timer_load  = 1'b0;
        adv         = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    cur_nxt   = start_val;
                    last_nxt  = end_val;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                // An accepted vector counts even when abort wins the same cycle.
                if (accept) cnt_nxt = vec_cnt + CW'(1);
                if (abort) begin
                    state_nxt   = S_IDLE;
                    aborted_nxt = 1'b1;
                end else if (accept) begin
                    timer_load = 1'b1;
                    if (HOLD == 1) begin
                        adv = 1'b1;
                    end else begin
                        state_nxt = S_HOLD;
                        busy_nxt  = 1'b1;
                    end
                end else begin
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_nxt   = S_IDLE;
                    aborted_nxt = 1'b1;
                end else if (timer_expire) begin
                    adv = 1'b1;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (adv) begin
            if (cur == last) begin
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
            end else begin
                cur_nxt   = cur + WIDTH'(1);
                state_nxt = S_RUN;
                valid_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cur       <= '0;
            last      <= '0;
            vec_out   <= '0;
            vec_valid <= 1'b0;
            vec_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            last      <= last_nxt;
            vec_out   <= to_vec(cur_nxt);
            vec_valid <= valid_nxt;
            vec_cnt   <= cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            aborted   <= aborted_nxt;
        end
    end

endmodule
